tempsens_cal_tx: RTL and testbench

Serial calibration transmitter for the temperature-sensor block. It accepts a parallel calibration word and drives the sensor's three-wire calibration port (CAL_CLK, CAL_DAT, CAL_ENA) with a framed, MSB-first bit stream. It is the sending end of that port, and sits between on-chip calibration logic (or a test harness) and the sensor's calibration inputs.

---
 rtl/tempsens_cal_tx.sv | 94 +++++++++
 tb/tb_tempsens_cal_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tempsens_cal_tx.sv
// tempsens_cal_tx: framed MSB-first serial transmitter for the temperature-sensor calibration port.
// All outputs are registered from the next-state values, so nothing is combinational from inputs.
module tempsens_cal_tx #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [DATA_W-1:0] DATA,
    output logic              READY,
    output logic              DONE,
    output logic              CAL_CLK,
    output logic              CAL_DAT,
    output logic              CAL_ENA
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, TAIL} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              clk_q, clk_d;
    logic              dat_q, dat_d;
    logic              ena_q, ena_d;
    logic              last;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            clk_q   <= 1'b0;
            dat_q   <= 1'b0;
            ena_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            clk_q   <= clk_d;
            dat_q   <= dat_d;
            ena_q   <= ena_d;
        end
    end

    // ready_q gates acceptance so START is ignored in the cycle right after reset release
    always_comb begin
        last    = cnt_q == CMAX;
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE: if (START && ready_q) begin
                state_d = LO;
                sh_d    = DATA;
                bit_d   = BW'(DATA_W - 1);
            end
            LO:   state_d = last ? HI : LO;
            HI:   if (last) begin
                state_d = (bit_q == '0) ? TAIL : LO;
                bit_d   = (bit_q == '0) ? bit_q : bit_q - 1'b1;
                sh_d    = (bit_q == '0) ? sh_q : sh_q << 1;
            end
            TAIL: state_d = last ? IDLE : TAIL;
        endcase
    end

    always_comb begin
        ready_d = state_d == IDLE;
        done_d  = state_q == TAIL && state_d == IDLE;
        ena_d   = state_d != IDLE;
        clk_d   = state_d == HI;
        dat_d   = (state_d == LO || state_d == HI) && sh_d[DATA_W-1];
    end

    assign READY   = ready_q;
    assign DONE    = done_q;
    assign CAL_CLK = clk_q;
    assign CAL_DAT = dat_q;
    assign CAL_ENA = ena_q;
endmodule

// File: tb/tb_tempsens_cal_tx.sv
// tb_tempsens_cal_tx: three instances (8/2, 8/1, 16/4); stimulus queues expected words,
// per-instance monitors decode frames off the serial pins and compare.
module tb_tempsens_cal_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start = '0;
    logic [15:0] data [3];
    wire  [2:0]  ready, done, cclk, dat, ena;

    logic [15:0] exp_q [3][$];
    int          cmp = 0;
    int          errs = 0;
    int          gap [3];
    int          dcount [3];
    logic        abort_ok = 1'b0;

    always #5 clk = ~clk;

    tempsens_cal_tx #(.DATA_W(8), .CLK_DIV(2)) u0 (
        .CLK(clk), .RESET(rst), .START(start[0]), .DATA(data[0][7:0]),
        .READY(ready[0]), .DONE(done[0]), .CAL_CLK(cclk[0]), .CAL_DAT(dat[0]), .CAL_ENA(ena[0]));
    tempsens_cal_tx #(.DATA_W(8), .CLK_DIV(1)) u1 (
        .CLK(clk), .RESET(rst), .START(start[1]), .DATA(data[1][7:0]),
        .READY(ready[1]), .DONE(done[1]), .CAL_CLK(cclk[1]), .CAL_DAT(dat[1]), .CAL_ENA(ena[1]));
    tempsens_cal_tx #(.DATA_W(16), .CLK_DIV(4)) u2 (
        .CLK(clk), .RESET(rst), .START(start[2]), .DATA(data[2]),
        .READY(ready[2]), .DONE(done[2]), .CAL_CLK(cclk[2]), .CAL_DAT(dat[2]), .CAL_ENA(ena[2]));

    task automatic check(input string name, input int i, input int got, input int want);
        cmp++;
        if (got != want) begin
            errs++;
            $display("FAIL %s inst%0d: got %0h want %0h", name, i, got, want);
        end
    endtask

    task automatic send(input int i, input logic [15:0] v, input bit push);
        @(negedge clk);
        data[i]  = v;
        start[i] = 1'b1;
        if (push) exp_q[i].push_back(v);
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int lim);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[i] && n < lim);
        check("done_timeout", i, int'(done[i]), 1);
    endtask

    for (genvar g = 0; g < 3; g++) begin : mon
        localparam int W = (g == 2) ? 16 : 8;
        localparam int D = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        logic        prev_ena = 1'b0, prev_clk = 1'b0, prev_dat = 1'b0;
        logic [15:0] word = '0;
        logic [15:0] want;
        int          nb = 0, len = 0, zeros = 0;

        always @(negedge clk) begin
            if (done[g]) begin
                dcount[g]++;
                check("done_at_ena_fall", g, int'(prev_ena && !ena[g]), 1);
            end
            if (prev_clk && cclk[g]) check("dat_stable_hi", g, int'(dat[g]), int'(prev_dat));
            if (cclk[g]) check("clk_within_ena", g, int'(ena[g]), 1);
            if (prev_ena && !ena[g] && !(abort_ok && !done[g])) begin
                check("done_with_fall", g, int'(done[g]), 1);
                check("ready_with_done", g, int'(ready[g]), 1);
                cmp++;
                if (exp_q[g].size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_frame inst%0d: got %0h want none", g, word);
                end else begin
                    want = exp_q[g].pop_front();
                    check("word", g, int'(word), int'(want));
                    check("rise_count", g, nb, W);
                    check("ena_len", g, len, (2 * W + 1) * D);
                end
            end
            if (ena[g] && !prev_ena) begin
                gap[g] = zeros;
                zeros  = 0;
                len    = 0;
                nb     = 0;
                word   = '0;
            end
            if (ena[g]) len++;
            else zeros++;
            if (cclk[g] && !prev_clk) begin
                word = {word[14:0], dat[g]};
                nb++;
            end
            prev_ena = ena[g];
            prev_clk = cclk[g];
            prev_dat = dat[g];
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            data[i]   = '0;
            gap[i]    = 0;
            dcount[i] = 0;
        end
        repeat (3) @(negedge clk);
        check("reset_ready", 0, int'(ready), 0);
        check("reset_outs", 0, int'({ena, cclk, dat, done}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 0, int'(ready), 7);

        // basic frame plus first-cycle latency
        send(0, 16'hA5, 1);
        check("lat_ena", 0, int'(ena[0]), 1);
        check("lat_msb", 0, int'(dat[0]), 1);
        check("lat_ready", 0, int'(ready[0]), 0);
        check("lat_clk", 0, int'(cclk[0]), 0);
        wait_done(0, 200);

        // START and DATA activity during a frame must not matter
        send(0, 16'hC3, 1);
        repeat (5) @(negedge clk);
        data[0]  = 16'h3C;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        data[0]  = 16'hFF;
        repeat (7) @(negedge clk);
        data[0]  = 16'h00;
        wait_done(0, 200);

        // reset in the HI phase of the 4th bit abandons the frame
        abort_ok = 1'b1;
        send(0, 16'h96, 0);
        repeat (14) @(posedge clk);
        #1;
        check("pre_abort_hi", 0, int'({ena[0], cclk[0]}), 3);
        rst = 1'b1;
        #1;
        check("abort_outs", 0, int'({ena[0], cclk[0], dat[0]}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        abort_ok = 1'b0;
        check("ready_after_abort", 0, int'(ready[0]), 1);
        send(0, 16'h5A, 1);
        wait_done(0, 200);

        // back-to-back frames with START held high
        @(negedge clk);
        data[1]  = 16'hFF;
        start[1] = 1'b1;
        exp_q[1].push_back(16'hFF);
        exp_q[1].push_back(16'h00);
        @(negedge clk);
        data[1] = 16'h00;
        wait_done(1, 100);
        @(negedge clk);
        start[1] = 1'b0;
        wait_done(1, 100);
        check("b2b_gap", 1, gap[1], 1);

        send(2, 16'h8001, 1);
        wait_done(2, 400);

        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) check("queue_drained", i, exp_q[i].size(), 0);
        check("done_pulses", 0, dcount[0], 3);
        check("done_pulses", 1, dcount[1], 2);
        check("done_pulses", 2, dcount[2], 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
